pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Control unit for a four-stage D-R-X-W pipeline. It tracks the instruction in
// each stage and detects read-after-write hazards against producers still in
// R or X. The register file is write-first, so a producer in W never causes a
// hazard. A hazard stalls Decode and puts a bubble into R. A taken branch in X
// flushes the wrong-path work in D and R, and flush takes priority over stall.
// All datapath controls are combinational from the current state and inputs,
// so a hazard raises stall in the same cycle.
module pipe_hazard_ctrl #(
    parameter int             OPW     = 4,
    parameter int             RAW     = 3,
    parameter logic [OPW-1:0] LOAD_OP = 4'b0000,
    parameter logic [OPW-1:0] ORI_OP  = 4'b0111,
    parameter logic [OPW-1:0] HALT_OP = 4'b1111,
    parameter int             CNTW    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OPW-1:0]  id_op,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [1:0]      id_rs_use,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_wr,
    input  logic            mem_ready,
    input  logic            ex_taken,
    output logic            mem_read,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            ir1_load,
    output logic            ir2_load,
    output logic            ir3_load,
    output logic            ir4_load,
    output logic            r1r2_load,
    output logic            r1_sel,
    output logic            rf_write,
    output logic            reg_in,
    output logic            stall,
    output logic            flush,
    output logic            halted,
    output logic [CNTW-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [RAW-1:0] rd;
        logic           wr;
        logic           ld;
    } stage_t;

    // True when a valid stage will write register r.
    function automatic logic writes_reg(input logic v, input stage_t s, input logic [RAW-1:0] r);
        return v & s.wr & (s.rd == r);
    endfunction

    state_t          state_r, state_nxt_s;
    logic            vd_r, vr_r, vx_r, vw_r;
    logic            vd_nxt_s, vr_nxt_s, vx_nxt_s, vw_nxt_s;
    stage_t          r_stg_r, x_stg_r, w_stg_r;
    stage_t          r_stg_nxt_s, x_stg_nxt_s, w_stg_nxt_s;
    logic [CNTW-1:0] stall_cnt_r;
    logic            run_s, match1_s, match2_s, hazard_s, flush_s, stall_s, halt_w_s;

    assign run_s    = (state_r == ST_RUN);
    assign match1_s = writes_reg(vr_r, r_stg_r, id_rs1) | writes_reg(vx_r, x_stg_r, id_rs1);
    assign match2_s = writes_reg(vr_r, r_stg_r, id_rs2) | writes_reg(vx_r, x_stg_r, id_rs2);
    assign hazard_s = run_s & vd_r & ((id_rs_use[0] & match1_s) | (id_rs_use[1] & match2_s));
    assign flush_s  = run_s & vx_r & ex_taken;
    assign stall_s  = hazard_s & ~flush_s;
    assign halt_w_s = vw_r & (w_stg_r.op == HALT_OP);
    assign stall_count = stall_cnt_r;

    // Next FSM state: IDLE lasts one cycle, and HALTED is left only through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = ST_RUN;
            ST_RUN:    state_nxt_s = halt_w_s ? ST_HALTED : ST_RUN;
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Next pipeline tracking state. The default holds every stage, which also freezes HALTED.
    always_comb begin
        vd_nxt_s    = vd_r;
        vr_nxt_s    = vr_r;
        vx_nxt_s    = vx_r;
        vw_nxt_s    = vw_r;
        r_stg_nxt_s = r_stg_r;
        x_stg_nxt_s = x_stg_r;
        w_stg_nxt_s = w_stg_r;
        if (run_s) begin
            if (flush_s) begin
                // D and R hold wrong-path work behind the taken branch.
                // Only the branch moves on to W.
                vd_nxt_s    = 1'b0;
                vr_nxt_s    = 1'b0;
                vx_nxt_s    = 1'b0;
                vw_nxt_s    = vx_r;
                w_stg_nxt_s = x_stg_r;
            end else if (stall_s) begin
                vr_nxt_s    = 1'b0;
                vx_nxt_s    = vr_r;
                x_stg_nxt_s = r_stg_r;
                vw_nxt_s    = vx_r;
                w_stg_nxt_s = x_stg_r;
            end else begin
                vd_nxt_s    = mem_ready;
                vr_nxt_s    = vd_r;
                r_stg_nxt_s = '{op: id_op, rd: id_rd, wr: id_wr, ld: (id_op == LOAD_OP)};
                vx_nxt_s    = vr_r;
                x_stg_nxt_s = r_stg_r;
                vw_nxt_s    = vx_r;
                w_stg_nxt_s = x_stg_r;
            end
        end else begin
            vd_nxt_s = vd_r;
        end
    end

    // FSM state and per-stage tracking registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            vd_r    <= 1'b0;
            vr_r    <= 1'b0;
            vx_r    <= 1'b0;
            vw_r    <= 1'b0;
            r_stg_r <= '0;
            x_stg_r <= '0;
            w_stg_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            vd_r    <= vd_nxt_s;
            vr_r    <= vr_nxt_s;
            vx_r    <= vx_nxt_s;
            vw_r    <= vw_nxt_s;
            r_stg_r <= r_stg_nxt_s;
            x_stg_r <= x_stg_nxt_s;
            w_stg_r <= w_stg_nxt_s;
        end
    end

    // Saturating count of hazard-stall cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CNTW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Datapath controls and status. Everything is 0 outside RUN, except halted.
    always_comb begin
        mem_read  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        ir1_load  = 1'b0;
        ir2_load  = 1'b0;
        ir3_load  = 1'b0;
        ir4_load  = 1'b0;
        r1r2_load = 1'b0;
        r1_sel    = 1'b0;
        rf_write  = 1'b0;
        reg_in    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        halted    = 1'b0;
        case (state_r)
            ST_RUN: begin
                // The halt instruction retires without writing the register file.
                rf_write = vw_r & w_stg_r.wr & ~halt_w_s;
                reg_in   = vw_r & w_stg_r.ld;
                r1_sel   = vd_r & (id_op == ORI_OP);
                if (flush_s) begin
                    pc_write = 1'b1;
                    ir2_load = 1'b1;
                    ir3_load = 1'b1;
                    ir4_load = 1'b1;
                    flush    = 1'b1;
                end else if (stall_s) begin
                    pc_sel    = 1'b1;
                    ir3_load  = 1'b1;
                    ir4_load  = 1'b1;
                    r1r2_load = 1'b1;
                    stall     = 1'b1;
                end else begin
                    mem_read  = 1'b1;
                    pc_sel    = 1'b1;
                    pc_write  = mem_ready;
                    ir1_load  = mem_ready;
                    ir2_load  = 1'b1;
                    ir3_load  = 1'b1;
                    ir4_load  = 1'b1;
                    r1r2_load = 1'b1;
                end
            end
            ST_HALTED: halted = 1'b1;
            ST_IDLE:   halted = 1'b0;
            default:   halted = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Each step drives one cycle of inputs and
// compares the control vector against the value expected for that cycle. Each
// instruction that enters R has its expected rf_write/reg_in pushed onto a
// retirement queue, and the entry is popped in the cycle the instruction
// should reach W. A second instance with a 2-bit counter runs on the same
// stimulus so that counter saturation can be observed.
module tb_pipe_hazard_ctrl;

    localparam logic [3:0] LOAD = 4'b0000;
    localparam logic [3:0] ALU  = 4'b0001;
    localparam logic [3:0] STR  = 4'b0010;
    localparam logic [3:0] BR   = 4'b0011;
    localparam logic [3:0] ORI  = 4'b0111;
    localparam logic [3:0] HALT = 4'b1111;

    // Bit order: mem_read pc_write pc_sel ir1 ir2 ir3 ir4 r1r2 stall flush halted
    localparam logic [10:0] CTL_IDLE  = 11'b00000000000;
    localparam logic [10:0] CTL_HALT  = 11'b00000000001;
    localparam logic [10:0] CTL_NORM  = 11'b11111111000;
    localparam logic [10:0] CTL_NRDY  = 11'b10101111000;
    localparam logic [10:0] CTL_STALL = 11'b00100111100;
    localparam logic [10:0] CTL_FLUSH = 11'b01001110010;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  id_op;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_rs_use;
    logic        id_wr, mem_ready, ex_taken;

    logic        mem_read, pc_write, pc_sel, ir1_load, ir2_load, ir3_load, ir4_load;
    logic        r1r2_load, r1_sel, rf_write, reg_in, stall, flush, halted;
    logic [15:0] stall_count;

    logic        s_mem_read, s_pc_write, s_pc_sel, s_ir1_load, s_ir2_load, s_ir3_load, s_ir4_load;
    logic        s_r1r2_load, s_r1_sel, s_rf_write, s_reg_in, s_stall, s_flush, s_halted;
    logic [1:0]  s_stall_count;

    logic [10:0] ctrl, s_ctrl;
    assign ctrl   = {mem_read, pc_write, pc_sel, ir1_load, ir2_load, ir3_load, ir4_load,
                     r1r2_load, stall, flush, halted};
    assign s_ctrl = {s_mem_read, s_pc_write, s_pc_sel, s_ir1_load, s_ir2_load, s_ir3_load,
                     s_ir4_load, s_r1r2_load, s_stall, s_flush, s_halted};

    typedef struct {
        int   cyc;
        logic rfw;
        logic ld;
    } ret_t;

    ret_t sb[$];
    int   cyc    = 0;
    int   sc     = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl u_dut (
        .clock(clock), .reset(reset), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs_use(id_rs_use), .id_rd(id_rd), .id_wr(id_wr), .mem_ready(mem_ready),
        .ex_taken(ex_taken), .mem_read(mem_read), .pc_write(pc_write), .pc_sel(pc_sel),
        .ir1_load(ir1_load), .ir2_load(ir2_load), .ir3_load(ir3_load), .ir4_load(ir4_load),
        .r1r2_load(r1r2_load), .r1_sel(r1_sel), .rf_write(rf_write), .reg_in(reg_in),
        .stall(stall), .flush(flush), .halted(halted), .stall_count(stall_count)
    );

    pipe_hazard_ctrl #(.CNTW(2)) u_sat (
        .clock(clock), .reset(reset), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs_use(id_rs_use), .id_rd(id_rd), .id_wr(id_wr), .mem_ready(mem_ready),
        .ex_taken(ex_taken), .mem_read(s_mem_read), .pc_write(s_pc_write), .pc_sel(s_pc_sel),
        .ir1_load(s_ir1_load), .ir2_load(s_ir2_load), .ir3_load(s_ir3_load),
        .ir4_load(s_ir4_load), .r1r2_load(s_r1r2_load), .r1_sel(s_r1_sel),
        .rf_write(s_rf_write), .reg_in(s_reg_in), .stall(s_stall), .flush(s_flush),
        .halted(s_halted), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic instr(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [1:0] use_, input logic [2:0] rd, input logic wr);
        id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rs_use = use_; id_rd = rd; id_wr = wr;
    endtask

    // Drive one cycle, check it, then advance to the next negedge.
    // dv: whether the bench expects a valid instruction in Decode this cycle.
    task automatic step(input logic mr, input logic tk, input logic dv, input logic [10:0] ec);
        logic run, er1, erfw, eld;
        int   sat;
        ret_t e;
        mem_ready = mr;
        ex_taken  = tk;
        #1;
        run  = (ec != CTL_IDLE) && (ec != CTL_HALT);
        er1  = run && dv && (id_op == ORI);
        erfw = 1'b0;
        eld  = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            erfw = sb[0].rfw;
            eld  = sb[0].ld;
            sb.delete(0);
        end
        sat = (sc > 3) ? 3 : sc;
        chk("ctrl",        {5'b0, ctrl}, {5'b0, ec});
        chk("stall_count", stall_count, 16'(sc));
        chk("rf_write",    {15'b0, rf_write}, {15'b0, erfw});
        chk("reg_in",      {15'b0, reg_in}, {15'b0, eld});
        chk("r1_sel",      {15'b0, r1_sel}, {15'b0, er1});
        chk("sat_ctrl",    {5'b0, s_ctrl}, {5'b0, ec});
        chk("sat_count",   {14'b0, s_stall_count}, 16'(sat));
        chk("sat_wb",      {13'b0, s_rf_write, s_reg_in, s_r1_sel}, {13'b0, erfw, eld, er1});
        if (ec[1]) begin
            // The instruction in R is wrong-path and never retires.
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc + 2) sb.delete(i);
            end
        end
        if (run && dv && !ec[2] && !ec[1]) begin
            e.cyc = cyc + 3;
            e.rfw = id_wr && (id_op != HALT);
            e.ld  = (id_op == LOAD);
            sb.push_back(e);
        end
        @(posedge clock);
        cyc++;
        if (ec[2]) sc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        sc = 0;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; ex_taken = 1'b0;
        instr(ALU, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0);
        do_reset();

        // Reset leaves IDLE for one cycle with every output at 0.
        instr(ORI, 3'd0, 3'd0, 2'b01, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, CTL_IDLE);

        // Independent instructions stream through. Each retires 4 cycles after its fetch.
        step(1'b1, 1'b0, 1'b0, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd1, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ORI,  3'd0, 3'd0, 2'b01, 3'd2, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(LOAD, 3'd5, 3'd0, 2'b01, 3'd4, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(STR,  3'd6, 3'd7, 2'b11, 3'd0, 1'b0); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        // Reads r0 while R holds a non-writing r0 target, so there is no hazard.
        instr(LOAD, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);

        // A load of r3 is in R and D reads r3: two stall cycles, with mem_ready ignored.
        instr(ALU,  3'd3, 3'd0, 2'b01, 3'd5, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b0, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);

        // Taken branch in X together with a hazard: flush wins and the count is unchanged.
        instr(BR,   3'd0, 3'd0, 2'b00, 3'd0, 1'b0); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(LOAD, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd6, 3'd0, 2'b01, 3'd7, 1'b1); step(1'b1, 1'b1, 1'b1, CTL_FLUSH);
        // D and R are empty: no stall and no r1_sel, and the flushed load never writes.
        instr(ORI,  3'd6, 3'd0, 2'b01, 3'd1, 1'b1); step(1'b1, 1'b0, 1'b0, CTL_NORM);

        // Three cycles without a memory word: no fetch, and bubbles reach W.
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd7, 1'b1); step(1'b0, 1'b0, 1'b1, CTL_NRDY);
        step(1'b0, 1'b0, 1'b0, CTL_NRDY);
        step(1'b0, 1'b0, 1'b0, CTL_NRDY);
        step(1'b1, 1'b0, 1'b0, CTL_NORM);

        // Halt reaches W, then everything goes quiet. Younger instructions never retire.
        instr(HALT, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd1, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd2, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd3, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        sb.delete();
        instr(ORI,  3'd1, 3'd0, 2'b01, 3'd0, 1'b1); step(1'b1, 1'b1, 1'b1, CTL_HALT);
        step(1'b1, 1'b1, 1'b1, CTL_HALT);

        // Reset from HALTED returns to IDLE with the counter cleared.
        do_reset();
        step(1'b1, 1'b0, 1'b0, CTL_IDLE);

        // Six stall cycles: the 2-bit counter saturates at 3 and the 16-bit counter reaches 6.
        step(1'b1, 1'b0, 1'b0, CTL_NORM);
        instr(LOAD, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd3, 3'd0, 2'b01, 3'd4, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(LOAD, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd2, 2'b10, 3'd5, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd6, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd6, 3'd0, 2'b01, 3'd1, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_STALL);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(LOAD, 3'd0, 3'd0, 2'b00, 3'd7, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);
        instr(ALU,  3'd0, 3'd0, 2'b00, 3'd0, 1'b1); step(1'b1, 1'b0, 1'b1, CTL_NORM);

        // Reset mid-operation discards the in-flight instructions, so no write appears afterwards.
        do_reset();
        step(1'b1, 1'b0, 1'b0, CTL_IDLE);
        instr(STR, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, CTL_NORM);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);
        step(1'b1, 1'b0, 1'b1, CTL_NORM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
